pwm_ramp: RTL and testbench

PWM_RAMP -- requirements
Module: pwm_ramp

---
 rtl/pwm_ramp.sv | 127 ++++++++++++
 tb/tb_pwm_ramp.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp.sv
// pwm_ramp: slews the PWM width toward a requested duty at a programmable rate.
// Latency: period/width update one cycle after accept; ramp steps every tick_div+1 cycles.
// Backpressure: none; target_ready is high whenever out of reset and retargets on the fly.
`timescale 1ns/1ps
module pwm_ramp #(
  parameter int BITS = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS+1:0] target_period,
  input  logic [BITS+1:0] target_width,
  input  logic [BITS+1:0] step,
  input  logic [15:0]     tick_div,
  input  logic            target_valid,
  output logic            target_ready,
  output logic [BITS+1:0] period,
  output logic [BITS+1:0] width,
  output logic            busy,
  output logic            done
);

  localparam int W = BITS + 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  // Architectural state
  state_t       r_state;
  logic [W-1:0] r_period;
  logic [W-1:0] r_width;
  logic [W-1:0] r_goal;
  logic [W-1:0] r_step;
  logic [15:0]  r_tick_div;
  logic [15:0]  r_presc;
  logic         r_ready;
  logic         r_done;

  // Combinational helpers
  logic         w_accept;
  logic [W-1:0] w_pmax;
  logic [W-1:0] w_new_goal;
  logic [W-1:0] w_clamped;
  logic         w_jump;
  logic         w_tick;
  logic         w_up;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_delta;
  logic [W-1:0] w_stepped;

  // Request decode: goal limit, clamp of the current width, and the jump decision
  always_comb begin
    w_accept   = target_valid && r_ready;
    // period+1 saturates so an all-ones period does not wrap the limit to zero
    w_pmax     = (&target_period) ? target_period : target_period + W'(1);
    w_new_goal = (target_width < w_pmax) ? target_width : w_pmax;
    // A shrinking period drags the live width down before any ramping
    w_clamped  = (r_width > w_pmax) ? w_pmax : r_width;
    w_jump     = (step == '0) || (w_new_goal == w_clamped);
  end

  // Ramp datapath: move toward the goal by at most one step, never past it
  always_comb begin
    // >= rather than == so a retarget with a smaller tick_div cannot strand the prescaler
    w_tick    = (r_state == ST_RAMP) && (r_presc >= r_tick_div);
    w_up      = (r_goal > r_width);
    w_diff    = w_up ? (r_goal - r_width) : (r_width - r_goal);
    w_delta   = (r_step < w_diff) ? r_step : w_diff;
    w_stepped = w_up ? (r_width + w_delta) : (r_width - w_delta);
  end

  // Control FSM with registered outputs; an accept always wins over a coincident tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_period   <= '0;
      r_width    <= '0;
      r_goal     <= '0;
      r_step     <= '0;
      r_tick_div <= '0;
      r_presc    <= '0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;

      // Prescaler free-runs in RAMP (an accept does not restart it), parked at 0 in IDLE
      if (r_state == ST_RAMP) begin
        r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      end else begin
        r_presc <= 16'd0;
      end

      if (w_accept) begin
        r_period   <= target_period;
        r_goal     <= w_new_goal;
        r_step     <= step;
        r_tick_div <= tick_div;
        if (w_jump) begin
          r_width <= w_new_goal;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
          r_presc <= 16'd0;
        end else begin
          r_width <= w_clamped;
          r_state <= ST_RAMP;
        end
      end else if (w_tick) begin
        r_width <= w_stepped;
        if (w_stepped == r_goal) begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
          r_presc <= 16'd0;
        end
      end
    end
  end

  assign target_ready = r_ready;
  assign period       = r_period;
  assign width        = r_width;
  assign busy         = (r_state == ST_RAMP);
  assign done         = r_done;

endmodule

// File: tb/tb_pwm_ramp.sv
// tb_pwm_ramp: scoreboard bench for pwm_ramp at BITS=8.
// Each scenario queues its expected per-cycle outputs, then pops one per clock.
// Outputs are sampled 1ns after the rising edge; inputs change at the same point.
`timescale 1ns/1ps
module tb_pwm_ramp;

  localparam int BITS = 8;
  localparam int W    = BITS + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] target_period;
  logic [W-1:0] target_width;
  logic [W-1:0] step;
  logic [15:0]  tick_div;
  logic         target_valid;
  logic         target_ready;
  logic [W-1:0] period;
  logic [W-1:0] width;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         ready;
    logic [W-1:0] period;
    logic [W-1:0] width;
    logic         busy;
    logic         done;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  pwm_ramp #(.BITS(BITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .target_period(target_period),
    .target_width (target_width),
    .step         (step),
    .tick_div     (tick_div),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .period       (period),
    .width        (width),
    .busy         (busy),
    .done         (done)
  );

  function automatic void push(input int r, input int p, input int w, input int b, input int d);
    obs_t e;
    e.ready  = r[0];
    e.period = p[W-1:0];
    e.width  = w[W-1:0];
    e.busy   = b[0];
    e.done   = d[0];
    exp_q.push_back(e);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ready  = target_ready;
    o.period = period;
    o.width  = width;
    o.busy   = busy;
    o.done   = done;
    return o;
  endfunction

  task automatic drive(input int p, input int w, input int s, input int td);
    target_period = p[W-1:0];
    target_width  = w[W-1:0];
    step          = s[W-1:0];
    tick_div      = td[15:0];
    target_valid  = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    reset = 1'b1;
    target_valid = 1'b0;
    target_period = '0;
    target_width = '0;
    step = '0;
    tick_div = '0;
    repeat (2) @(posedge clk);
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_hold: got rdy=%b p=%0d w=%0d busy=%b done=%b, want all zero",
               o.ready, o.period, o.width, o.busy, o.done);
    end
    reset = 1'b0;
    push(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL reset_release: no expectation queued");
    end else begin
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_release: got rdy=%b p=%0d w=%0d busy=%b done=%b, want rdy=%b p=%0d w=%0d busy=%b done=%b",
                 o.ready, o.period, o.width, o.busy, o.done, e.ready, e.period, e.width, e.busy, e.done);
      end
    end
  endtask

  task automatic test_ramp_up();
    obs_t e, o;
    push(1, 99, 0, 1, 0);
    push(1, 99, 10, 1, 0);
    push(1, 99, 20, 1, 0);
    push(1, 99, 30, 1, 0);
    push(1, 99, 40, 0, 1);
    push(1, 99, 40, 0, 0);
    drive(99, 40, 10, 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      target_valid = 1'b0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ramp_up[%0d]: no expectation queued", c);
      end else begin
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL ramp_up[%0d]: got rdy=%b p=%0d w=%0d busy=%b done=%b, want rdy=%b p=%0d w=%0d busy=%b done=%b",
                   c, o.ready, o.period, o.width, o.busy, o.done, e.ready, e.period, e.width, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic test_jump();
    obs_t e, o;
    // goal = min(50, 9+1) = 10; width 40 is clamped and lands on the goal at once
    push(1, 9, 10, 0, 1);
    push(1, 9, 10, 0, 0);
    push(1, 9, 10, 0, 0);
    drive(9, 50, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      target_valid = 1'b0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL jump[%0d]: no expectation queued", c);
      end else begin
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL jump[%0d]: got rdy=%b p=%0d w=%0d busy=%b done=%b, want rdy=%b p=%0d w=%0d busy=%b done=%b",
                   c, o.ready, o.period, o.width, o.busy, o.done, e.ready, e.period, e.width, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic test_prescaler();
    obs_t e, o;
    push(1, 99, 0, 0, 1);
    for (int i = 0; i < 4; i++) push(1, 99, 0, 1, 0);
    for (int i = 0; i < 4; i++) push(1, 99, 7, 1, 0);
    for (int i = 0; i < 4; i++) push(1, 99, 14, 1, 0);
    push(1, 99, 20, 0, 1);
    push(1, 99, 20, 0, 0);
    drive(99, 0, 0, 0);
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) drive(99, 20, 7, 3);
      else target_valid = 1'b0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL prescaler[%0d]: no expectation queued", c);
      end else begin
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL prescaler[%0d]: got rdy=%b p=%0d w=%0d busy=%b done=%b, want rdy=%b p=%0d w=%0d busy=%b done=%b",
                   c, o.ready, o.period, o.width, o.busy, o.done, e.ready, e.period, e.width, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic test_retarget();
    obs_t e, o;
    push(1, 99, 20, 1, 0);
    push(1, 99, 30, 1, 0);
    push(1, 99, 30, 1, 0);   // accept coincides with a tick: no step taken
    push(1, 99, 25, 1, 0);
    push(1, 99, 20, 1, 0);
    push(1, 99, 15, 1, 0);
    push(1, 99, 10, 0, 1);
    push(1, 99, 10, 0, 0);
    drive(99, 90, 10, 0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) drive(99, 10, 5, 0);
      else target_valid = 1'b0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL retarget[%0d]: no expectation queued", c);
      end else begin
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL retarget[%0d]: got rdy=%b p=%0d w=%0d busy=%b done=%b, want rdy=%b p=%0d w=%0d busy=%b done=%b",
                   c, o.ready, o.period, o.width, o.busy, o.done, e.ready, e.period, e.width, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic test_clamp();
    obs_t e, o;
    push(1, 99, 60, 0, 1);
    push(1, 19, 20, 1, 0);   // width 60 clamped to 19+1 at the accept edge
    push(1, 19, 17, 1, 0);
    push(1, 19, 14, 1, 0);
    push(1, 19, 11, 1, 0);
    push(1, 19, 8, 1, 0);
    push(1, 19, 5, 0, 1);
    push(1, 19, 5, 0, 0);
    drive(99, 60, 0, 0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) drive(19, 5, 3, 0);
      else target_valid = 1'b0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL clamp[%0d]: no expectation queued", c);
      end else begin
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL clamp[%0d]: got rdy=%b p=%0d w=%0d busy=%b done=%b, want rdy=%b p=%0d w=%0d busy=%b done=%b",
                   c, o.ready, o.period, o.width, o.busy, o.done, e.ready, e.period, e.width, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic test_saturate();
    obs_t e, o;
    push(1, 1023, 1023, 0, 1);   // period+1 saturates at all-ones
    push(1, 500, 501, 0, 1);     // clamped width equals goal: jump despite nonzero step
    push(1, 500, 501, 0, 0);
    drive(1023, 1023, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) drive(500, 1023, 9, 0);
      else target_valid = 1'b0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL saturate[%0d]: no expectation queued", c);
      end else begin
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL saturate[%0d]: got rdy=%b p=%0d w=%0d busy=%b done=%b, want rdy=%b p=%0d w=%0d busy=%b done=%b",
                   c, o.ready, o.period, o.width, o.busy, o.done, e.ready, e.period, e.width, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    push(1, 50, 7, 0, 1);
    push(1, 50, 9, 0, 1);
    push(1, 50, 9, 1, 0);
    push(1, 50, 9, 1, 0);
    push(1, 50, 13, 1, 0);
    push(1, 50, 13, 0, 1);    // retarget onto the current width ends the ramp
    push(1, 50, 13, 0, 0);
    drive(50, 7, 0, 0);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      case (c)
        0:       drive(50, 9, 0, 0);
        1:       drive(50, 40, 4, 1);
        4:       drive(50, 13, 4, 1);
        default: target_valid = 1'b0;
      endcase
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL back_to_back[%0d]: no expectation queued", c);
      end else begin
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got rdy=%b p=%0d w=%0d busy=%b done=%b, want rdy=%b p=%0d w=%0d busy=%b done=%b",
                   c, o.ready, o.period, o.width, o.busy, o.done, e.ready, e.period, e.width, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic test_reset_midramp();
    obs_t e, o;
    push(1, 99, 0, 0, 1);
    push(1, 99, 0, 1, 0);
    push(1, 99, 10, 1, 0);
    push(1, 99, 20, 1, 0);
    push(1, 99, 30, 1, 0);
    drive(99, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) drive(99, 90, 10, 0);
      else target_valid = 1'b0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL midramp[%0d]: no expectation queued", c);
      end else begin
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL midramp[%0d]: got rdy=%b p=%0d w=%0d busy=%b done=%b, want rdy=%b p=%0d w=%0d busy=%b done=%b",
                   c, o.ready, o.period, o.width, o.busy, o.done, e.ready, e.period, e.width, e.busy, e.done);
        end
      end
    end
    // Assert reset between edges: outputs must clear without waiting for a clock
    #1;
    reset = 1'b1;
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b p=%0d w=%0d busy=%b done=%b, want all zero",
               o.ready, o.period, o.width, o.busy, o.done);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || width !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done[%0d]: got done=%b w=%0d busy=%b, want done=0 w=0 busy=0",
                 c, done, width, busy);
      end
    end
    reset = 1'b0;
    push(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL midramp_release: no expectation queued");
    end else begin
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midramp_release: got rdy=%b p=%0d w=%0d busy=%b done=%b, want rdy=%b p=%0d w=%0d busy=%b done=%b",
                 o.ready, o.period, o.width, o.busy, o.done, e.ready, e.period, e.width, e.busy, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_jump();
    test_prescaler();
    test_retarget();
    test_clamp();
    test_saturate();
    test_back_to_back();
    test_reset_midramp();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
